// File: rtl/cyp_fifo_ctrl_if.sv
// FX2 slave-FIFO bus plus the RX/TX stream handshakes of the FIFO controller.
// master = controller side, slave = FX2 pins and stream endpoints.
interface cyp_fifo_ctrl_if #(
  parameter int DW = 16
);
  logic          en;
  logic          usb_flaga;
  logic          usb_flagc;
  logic [DW-1:0] usb_fd_i;
  logic [DW-1:0] usb_fd_o;
  logic          usb_fd_oe;
  logic [1:0]    usb_fifoaddr;
  logic          usb_slcs;
  logic          usb_sloe;
  logic          usb_slrd;
  logic          usb_slwr;
  logic          usb_pktend;
  logic [DW-1:0] rx_data;
  logic          rx_wen;
  logic          rx_afull;
  logic [DW-1:0] tx_data;
  logic          tx_valid;
  logic          tx_ready;

  modport master (
    input  en, usb_flaga, usb_flagc, usb_fd_i, rx_afull, tx_data, tx_valid,
    output usb_fd_o, usb_fd_oe, usb_fifoaddr, usb_slcs, usb_sloe, usb_slrd,
           usb_slwr, usb_pktend, rx_data, rx_wen, tx_ready
  );

  modport slave (
    output en, usb_flaga, usb_flagc, usb_fd_i, rx_afull, tx_data, tx_valid,
    input  usb_fd_o, usb_fd_oe, usb_fifoaddr, usb_slcs, usb_sloe, usb_slrd,
           usb_slwr, usb_pktend, rx_data, rx_wen, tx_ready
  );
endinterface

// File: rtl/cyp_fifo_ctrl.sv
// Cypress FX2 slave-FIFO controller: EP2 OUT reads into an RX stream, TX stream
// writes to EP6 IN with short-packet commit on idle, round-robin arbitration.
module cyp_fifo_ctrl #(
  parameter int DW        = 16,
  parameter int PKT_WORDS = 256,
  parameter int IDLE_CLKS = 64,
  parameter int RD_BURST  = 256
) (
  input logic             cyp_clk,
  input logic             rst,
  cyp_fifo_ctrl_if.master bus
);

  localparam int PW = (PKT_WORDS > 1) ? $clog2(PKT_WORDS) : 1;
  localparam int IW = (IDLE_CLKS > 1) ? $clog2(IDLE_CLKS) : 1;
  localparam int BW = $clog2(RD_BURST + 1);
  localparam logic [PW-1:0] PKT_LAST  = PW'(PKT_WORDS - 1);
  localparam logic [IW-1:0] IDLE_LAST = IW'(IDLE_CLKS - 1);
  localparam logic [BW-1:0] BURST_MAX = BW'(RD_BURST);

  typedef enum logic [2:0] {IDLE, RD_OE, RD, TURN, WR, PKTEND} state_e;

  state_e        state_q, state_d;
  logic [BW-1:0] burst_cnt_q, burst_cnt_d;
  logic [PW-1:0] pkt_cnt_q, pkt_cnt_d;
  logic [IW-1:0] idle_cnt_q, idle_cnt_d;
  logic          last_rd_q, last_rd_d;
  logic [1:0]    fifoaddr_q, fifoaddr_d;
  logic [DW-1:0] rx_data_q, rx_data_d;
  logic          rx_wen_q, rx_wen_d;

  logic          rd_req, wr_req, rd_go;
  logic          slrd_n, slwr_n, sloe_n, pktend_n, fd_oe, tx_ready;
  logic [1:0]    fifoaddr_o;
  logic [DW-1:0] fd_o;

  always_comb begin
    state_d     = state_q;
    burst_cnt_d = burst_cnt_q;
    pkt_cnt_d   = pkt_cnt_q;
    idle_cnt_d  = idle_cnt_q;
    last_rd_d   = last_rd_q;
    fifoaddr_d  = fifoaddr_q;
    rx_data_d   = rx_data_q;
    rx_wen_d    = 1'b0;
    slrd_n      = 1'b1;
    slwr_n      = 1'b1;
    sloe_n      = 1'b1;
    pktend_n    = 1'b1;
    fd_oe       = 1'b0;
    fd_o        = '0;
    tx_ready    = 1'b0;

    rd_req = bus.usb_flaga & ~bus.rx_afull;
    wr_req = bus.usb_flagc & bus.tx_valid;
    rd_go  = rd_req & (burst_cnt_q < BURST_MAX);

    unique case (state_q)
      IDLE: begin
        if (bus.en) begin
          if (rd_req && (!wr_req || !last_rd_q)) begin
            state_d   = RD_OE;
            last_rd_d = 1'b1;
          end else if (wr_req) begin
            state_d   = TURN;
            last_rd_d = 1'b0;
          end
        end
      end
      RD_OE: begin
        sloe_n      = 1'b0;
        fifoaddr_d  = 2'b00;
        burst_cnt_d = '0;
        state_d     = RD;
      end
      RD: begin
        sloe_n     = 1'b0;
        fifoaddr_d = 2'b00;
        if (rd_go) begin
          slrd_n      = 1'b0;
          rx_data_d   = bus.usb_fd_i;
          rx_wen_d    = 1'b1;
          burst_cnt_d = burst_cnt_q + 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      TURN: begin
        fifoaddr_d  = 2'b10;
        burst_cnt_d = '0;
        idle_cnt_d  = '0;
        state_d     = WR;
      end
      WR: begin
        fifoaddr_d = 2'b10;
        fd_oe      = 1'b1;
        fd_o       = bus.tx_data;
        if (wr_req) begin
          slwr_n     = 1'b0;
          tx_ready   = 1'b1;
          idle_cnt_d = '0;
          pkt_cnt_d  = (pkt_cnt_q == PKT_LAST) ? '0 : pkt_cnt_q + 1'b1;
          if (burst_cnt_q < BURST_MAX) burst_cnt_d = burst_cnt_q + 1'b1;
        end else begin
          idle_cnt_d = idle_cnt_q + 1'b1;
        end
        // Writes share the read burst cap so a waiting EP2 read gets alternate turns.
        if (!wr_req && idle_cnt_q == IDLE_LAST)
          state_d = (pkt_cnt_q != '0) ? PKTEND : IDLE;
        else if (bus.usb_flaga && !last_rd_q && burst_cnt_d == BURST_MAX)
          state_d = IDLE;
      end
      PKTEND: begin
        fifoaddr_d = 2'b10;
        if (bus.usb_flagc) begin
          pktend_n  = 1'b0;
          pkt_cnt_d = '0;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    fifoaddr_o = fifoaddr_d;
    // Reset silences the pins combinationally, before the state flops clear.
    if (rst) begin
      slrd_n     = 1'b1;
      slwr_n     = 1'b1;
      sloe_n     = 1'b1;
      pktend_n   = 1'b1;
      fd_oe      = 1'b0;
      fd_o       = '0;
      tx_ready   = 1'b0;
      fifoaddr_o = 2'b00;
    end
  end

  always_ff @(posedge cyp_clk) begin
    if (rst) begin
      state_q     <= IDLE;
      burst_cnt_q <= '0;
      pkt_cnt_q   <= '0;
      idle_cnt_q  <= '0;
      last_rd_q   <= 1'b0;
      fifoaddr_q  <= 2'b00;
      rx_data_q   <= '0;
      rx_wen_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      burst_cnt_q <= burst_cnt_d;
      pkt_cnt_q   <= pkt_cnt_d;
      idle_cnt_q  <= idle_cnt_d;
      last_rd_q   <= last_rd_d;
      fifoaddr_q  <= fifoaddr_d;
      rx_data_q   <= rx_data_d;
      rx_wen_q    <= rx_wen_d;
    end
  end

  assign bus.usb_slrd     = slrd_n;
  assign bus.usb_slwr     = slwr_n;
  assign bus.usb_sloe     = sloe_n;
  assign bus.usb_pktend   = pktend_n;
  assign bus.usb_slcs     = 1'b0;
  assign bus.usb_fd_oe    = fd_oe;
  assign bus.usb_fd_o     = fd_o;
  assign bus.usb_fifoaddr = fifoaddr_o;
  assign bus.tx_ready     = tx_ready;
  assign bus.rx_wen       = rx_wen_q & ~rst;
  assign bus.rx_data      = rst ? '0 : rx_data_q;

endmodule

// File: tb/tb_cyp_fifo_ctrl.sv
// Scoreboard bench for cyp_fifo_ctrl: FX2 EP2/EP6 model around a default
// instance, plus an RD_BURST=4 instance for read/write contention.
module tb_cyp_fifo_ctrl;

  logic cyp_clk;
  logic rst, rst_c;
  initial cyp_clk = 1'b0;
  always #5 cyp_clk = ~cyp_clk;

  cyp_fifo_ctrl_if #(.DW(16)) bus ();
  cyp_fifo_ctrl_if #(.DW(16)) bus_c ();

  cyp_fifo_ctrl #(.DW(16), .PKT_WORDS(256), .IDLE_CLKS(64), .RD_BURST(256)) dut (
    .cyp_clk(cyp_clk), .rst(rst), .bus(bus));
  cyp_fifo_ctrl #(.DW(16), .PKT_WORDS(256), .IDLE_CLKS(64), .RD_BURST(4)) dut_c (
    .cyp_clk(cyp_clk), .rst(rst_c), .bus(bus_c));

  int n_cmp = 0, n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  logic [15:0] ep2_q[$], exp_rx[$], tx_q[$], exp_tx[$];
  bit rd_fire = 0, wr_fire = 0, prev_slrd = 1, prev_sloe = 1;
  bit rst_req = 1, en_req = 0, afull_req = 0, flagc_req = 1;
  int cyc = 0, rd_cnt = 0, rd_runs = 0, wen_cnt = 0, wr_cnt = 0, pe_cnt = 0;
  int last_wr_cyc = 0, pe_cyc = 0;

  task automatic push_rx(input int n);
    logic [15:0] w;
    for (int i = 0; i < n; i++) begin
      w = 16'($urandom);
      ep2_q.push_back(w);
      exp_rx.push_back(w);
    end
  endtask

  task automatic push_tx(input int n);
    logic [15:0] w;
    for (int i = 0; i < n; i++) begin
      w = 16'($urandom);
      tx_q.push_back(w);
      exp_tx.push_back(w);
    end
  endtask

  // One clock of the FX2/stream model: consume, check registered outputs, drive, check strobes.
  task automatic tick();
    int nstb;
    @(negedge cyp_clk);
    cyc++;
    if (rd_fire) void'(ep2_q.pop_front());
    if (wr_fire) void'(tx_q.pop_front());
    chk("rx_wen_lat", bus.rx_wen, rd_fire);
    if (bus.rx_wen) begin
      wen_cnt++;
      if (exp_rx.size() == 0) chk("rx_extra", bus.rx_data, 32'hdead_beef);
      else chk("rx_data", bus.rx_data, exp_rx.pop_front());
    end
    rst              = rst_req;
    bus.en           = en_req;
    bus.rx_afull     = afull_req;
    bus.usb_flagc    = flagc_req;
    bus.usb_flaga    = (ep2_q.size() != 0);
    bus.usb_fd_i     = (ep2_q.size() != 0) ? ep2_q[0] : 16'h0;
    bus.tx_valid     = (tx_q.size() != 0);
    bus.tx_data      = (tx_q.size() != 0) ? tx_q[0] : 16'h0;
    #1;
    nstb = int'(!bus.usb_slrd) + int'(!bus.usb_slwr) + int'(!bus.usb_pktend);
    chk("strobe_excl", nstb > 1, 0);
    chk("sloe_vs_oe", !bus.usb_sloe && bus.usb_fd_oe, 0);
    chk("tx_ready", bus.tx_ready, !bus.usb_slwr);
    if (bus.rx_afull) chk("afull_slrd", bus.usb_slrd, 1);
    rd_fire = !bus.usb_slrd;
    wr_fire = !bus.usb_slwr;
    if (rd_fire) begin
      rd_cnt++;
      chk("rd_addr", bus.usb_fifoaddr, 2'b00);
      if (prev_slrd) begin
        rd_runs++;
        chk("rd_after_oe", prev_sloe, 0);
      end
    end
    if (wr_fire) begin
      wr_cnt++;
      last_wr_cyc = cyc;
      chk("wr_addr", bus.usb_fifoaddr, 2'b10);
      chk("wr_fd_oe", bus.usb_fd_oe, 1);
      if (exp_tx.size() == 0) chk("wr_extra", bus.usb_fd_o, 32'hdead_beef);
      else chk("wr_data", bus.usb_fd_o, exp_tx.pop_front());
    end
    if (!bus.usb_pktend) begin
      pe_cnt++;
      pe_cyc = cyc;
      chk("pe_addr", bus.usb_fifoaddr, 2'b10);
    end
    prev_slrd = bus.usb_slrd;
    prev_sloe = bus.usb_sloe;
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_slrd"}, bus.usb_slrd, 1);
    chk({tag, "_slwr"}, bus.usb_slwr, 1);
    chk({tag, "_sloe"}, bus.usb_sloe, 1);
    chk({tag, "_pktend"}, bus.usb_pktend, 1);
    chk({tag, "_fd_oe"}, bus.usb_fd_oe, 0);
    chk({tag, "_fifoaddr"}, bus.usb_fifoaddr, 0);
    chk({tag, "_slcs"}, bus.usb_slcs, 0);
    chk({tag, "_rx_wen"}, bus.rx_wen, 0);
    chk({tag, "_tx_ready"}, bus.tx_ready, 0);
    chk({tag, "_rx_data"}, bus.rx_data, 0);
    chk({tag, "_fd_o"}, bus.usb_fd_o, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int b_rd, b_runs, b_wen, b_wr, b_pe;
    int c_rd_word, c_wr_word, prev_kind, kind, cur_len;
    bit c_rd, c_wr;
    logic [15:0] exp_c[$];
    int runs_k[$], runs_len[$];

    rst = 1'b1; rst_c = 1'b1;
    bus.en = 0; bus.usb_flaga = 0; bus.usb_flagc = 1; bus.usb_fd_i = '0;
    bus.rx_afull = 0; bus.tx_data = '0; bus.tx_valid = 0;
    bus_c.en = 1; bus_c.usb_flaga = 1; bus_c.usb_flagc = 1; bus_c.usb_fd_i = '0;
    bus_c.rx_afull = 0; bus_c.tx_data = '0; bus_c.tx_valid = 1;

    // Reset values, during reset and in the cycle after
    tick(); tick();
    check_reset("rst");
    rst_req = 0;
    tick();
    check_reset("post_rst");

    // EP2 read of 10 words; en dropped mid-burst must not abort it
    en_req = 1;
    b_rd = rd_cnt; b_runs = rd_runs; b_wen = wen_cnt;
    push_rx(10);
    for (int g = 0; g < 200 && (rd_cnt - b_rd) < 3; g++) tick();
    en_req = 0;
    for (int g = 0; g < 200 && (rd_cnt - b_rd) < 10; g++) tick();
    repeat (3) tick();
    chk("rd10_count", rd_cnt - b_rd, 10);
    chk("rd10_wen", wen_cnt - b_wen, 10);
    chk("rd10_one_burst", rd_runs - b_runs, 1);
    chk("rd10_sb_empty", exp_rx.size(), 0);
    push_rx(3);
    repeat (20) tick();
    chk("en0_no_read", rd_cnt - b_rd, 10);
    en_req = 1;
    for (int g = 0; g < 200 && (rd_cnt - b_rd) < 13; g++) tick();
    repeat (3) tick();
    chk("en1_resume", rd_cnt - b_rd, 13);
    chk("en1_sb_empty", exp_rx.size(), 0);

    // Read backpressure after word 4
    b_rd = rd_cnt; b_runs = rd_runs; b_wen = wen_cnt;
    push_rx(10);
    for (int g = 0; g < 200 && (rd_cnt - b_rd) < 4; g++) tick();
    afull_req = 1;
    repeat (6) tick();
    chk("afull_reads", rd_cnt - b_rd, 4);
    chk("afull_wen", wen_cnt - b_wen, 4);
    afull_req = 0;
    for (int g = 0; g < 200 && (rd_cnt - b_rd) < 10; g++) tick();
    repeat (3) tick();
    chk("afull_total", rd_cnt - b_rd, 10);
    chk("afull_resume_runs", rd_runs - b_runs, 2);
    chk("afull_sb_empty", exp_rx.size(), 0);

    // Full EP6 packet: auto-commit, no pktend
    b_wr = wr_cnt; b_pe = pe_cnt;
    push_tx(256);
    for (int g = 0; g < 3000 && (wr_cnt - b_wr) < 256; g++) tick();
    repeat (80) tick();
    chk("pkt256_writes", wr_cnt - b_wr, 256);
    chk("pkt256_no_pktend", pe_cnt - b_pe, 0);
    chk("pkt256_sb_empty", exp_tx.size(), 0);

    // Short packet: 5 words then idle timeout commits it
    b_wr = wr_cnt; b_pe = pe_cnt;
    push_tx(5);
    for (int g = 0; g < 200 && (wr_cnt - b_wr) < 5; g++) tick();
    repeat (80) tick();
    chk("short_pktend", pe_cnt - b_pe, 1);
    chk("short_pe_gap", pe_cyc - last_wr_cyc, 65);
    // pkt_cnt cleared: 251 more words form a short packet, not a wrap
    b_wr = wr_cnt; b_pe = pe_cnt;
    push_tx(251);
    for (int g = 0; g < 3000 && (wr_cnt - b_wr) < 251; g++) tick();
    repeat (80) tick();
    chk("short_clr_writes", wr_cnt - b_wr, 251);
    chk("short_clr_pktend", pe_cnt - b_pe, 1);

    // Reset mid-WR at pkt_cnt=3 abandons the packet
    b_wr = wr_cnt; b_pe = pe_cnt;
    push_tx(10);
    for (int g = 0; g < 200 && (wr_cnt - b_wr) < 3; g++) tick();
    rst_req = 1;
    tick();
    check_reset("mid_rst");
    tx_q.delete();
    exp_tx.delete();
    rst_req = 0;
    tick();
    check_reset("mid_rst_post");
    chk("mid_rst_no_pktend", pe_cnt - b_pe, 0);
    b_wr = wr_cnt; b_pe = pe_cnt;
    push_tx(253);
    for (int g = 0; g < 3000 && (wr_cnt - b_wr) < 253; g++) tick();
    repeat (80) tick();
    chk("mid_rst_pkt_clr", pe_cnt - b_pe, 1);

    // Contention on the RD_BURST=4 instance
    c_rd_word = 16'h100; c_wr_word = 16'h800; c_rd = 0; c_wr = 0;
    prev_kind = 0; cur_len = 0;
    repeat (2) @(negedge cyp_clk);
    rst_c = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge cyp_clk);
      if (c_rd) c_rd_word++;
      if (c_wr) c_wr_word++;
      if (bus_c.rx_wen) begin
        if (exp_c.size() == 0) chk("c_rx_extra", bus_c.rx_data, 32'hdead_beef);
        else chk("c_rx_data", bus_c.rx_data, exp_c.pop_front());
      end
      bus_c.usb_fd_i = 16'(c_rd_word);
      bus_c.tx_data  = 16'(c_wr_word);
      #1;
      chk("c_oe_excl", !bus_c.usb_sloe && bus_c.usb_fd_oe, 0);
      c_rd = !bus_c.usb_slrd;
      c_wr = !bus_c.usb_slwr;
      chk("c_strobe_excl", c_rd && c_wr, 0);
      if (c_rd) exp_c.push_back(16'(c_rd_word));
      if (c_wr) chk("c_wr_data", bus_c.usb_fd_o, 16'(c_wr_word));
      kind = c_rd ? 1 : (c_wr ? 2 : 0);
      if (kind != 0 && kind == prev_kind) cur_len++;
      else begin
        if (prev_kind != 0) begin
          runs_k.push_back(prev_kind);
          runs_len.push_back(cur_len);
        end
        if (kind != 0) begin
          chk("c_gap", prev_kind, 0);
          cur_len = 1;
        end
      end
      prev_kind = kind;
    end
    chk("c_run_count", runs_k.size() >= 8, 1);
    for (int i = 0; i < 8 && i < runs_k.size(); i++) begin
      chk($sformatf("c_run%0d_kind", i), runs_k[i], (i % 2 == 0) ? 1 : 2);
      chk($sformatf("c_run%0d_len", i), runs_len[i], 4);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
